sdram_access_arbiter: RTL and testbench

//  Shares one Avalon-MM master port to the SDRAM controller between two requesters.

---
 rtl/vga_mem_pkg.sv | 16 +
 rtl/rd_pending_tracker.sv | 33 +++
 rtl/sdram_access_arbiter.sv | 116 +++++++++++
 tb/tb_sdram_access_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared widths and arbiter state encoding for the VGA frame fetch, the game-logic
// writer and the SDRAM access arbiter.
package vga_mem_pkg;
  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 16;
  localparam int BURST_MAX = 16;
  localparam int LEN_W     = $clog2(BURST_MAX + 1);
  localparam int MAX_PEND  = 8;
  localparam int WR_FAIR   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rd_pending_tracker.sv
// Counts reads accepted by the SDRAM controller but not yet returned.
// Also flags a full window and drops responses that arrive with nothing outstanding.
module rd_pending_tracker #(
  parameter int MAX_PEND = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_acc,
  input  logic i_rdv,
  output logic o_stall,
  output logic o_rdv_ok,
  output logic o_busy
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic [CNT_W-1:0] r_pend;
  logic             w_rdv_ok;

  // A response with nothing outstanding is left over from before a reset.
  assign w_rdv_ok = i_rdv && (r_pend != '0);
  assign o_rdv_ok = w_rdv_ok;
  assign o_stall  = (r_pend == CNT_W'(MAX_PEND));
  assign o_busy   = (r_pend != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pend <= '0;
    else if (i_acc && !w_rdv_ok && !o_stall)
      r_pend <= r_pend + 1'b1;
    else if (!i_acc && w_rdv_ok)
      r_pend <= r_pend - 1'b1;
  end
endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares one Avalon-MM master between VGA burst reads (priority) and single writes
// from game logic; a starvation count forces a waiting write after WR_FAIR bursts.
module sdram_access_arbiter
  import vga_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req_valid,
  input  logic [ADDR_W-1:0] vga_req_addr,
  input  logic [LEN_W-1:0]  vga_req_len,
  output logic              vga_req_ready,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [1:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              busy
);
  localparam int SW = $clog2(WR_FAIR + 1);

  arb_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len, r_issued;
  logic [SW-1:0]     r_starve;
  logic              r_req_ready, r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_stall, w_rdv_ok, w_pend_busy, w_acc, w_rd_done;

  rd_pending_tracker #(.MAX_PEND(MAX_PEND)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .i_acc    (w_acc),
    .i_rdv    (m_readdatavalid),
    .o_stall  (w_stall),
    .o_rdv_ok (w_rdv_ok),
    .o_busy   (w_pend_busy)
  );

  // A stall can only begin on an accept, so m_read never drops mid-waitrequest.
  assign m_read    = (r_state == ARB_RD) && (r_issued != r_len) && !w_stall;
  assign m_write   = (r_state == ARB_WR);
  assign w_acc     = m_read && !m_waitrequest;
  assign w_rd_done = (r_state == ARB_RD) &&
                     ((r_issued == r_len) || (w_acc && (r_issued + 1'b1 == r_len)));
  assign wr_ready  = m_write && !m_waitrequest;

  assign m_writedata   = m_write ? wr_data : '0;
  assign m_byteenable  = (m_read || m_write) ? 2'b11 : 2'b00;
  assign vga_req_ready = r_req_ready;
  assign vga_rvalid    = r_rvalid;
  assign vga_rdata     = r_rdata;
  assign busy          = (r_state != ARB_IDLE) || w_pend_busy;

  always_comb begin
    m_address = '0;
    if (r_state == ARB_RD)
      m_address = r_base + ADDR_W'(r_issued);
    else if (r_state == ARB_WR)
      m_address = wr_addr;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (wr_valid && ((r_starve == SW'(WR_FAIR)) || !vga_req_valid))
          w_next = ARB_WR;
        else if (vga_req_valid)
          w_next = ARB_RD;
      end
      ARB_RD:  if (w_rd_done) w_next = ARB_IDLE;
      ARB_WR:  if (!m_waitrequest) w_next = ARB_IDLE;
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_starve    <= '0;
      r_req_ready <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= 1'b0;
      if (r_state == ARB_IDLE && w_next == ARB_RD) begin
        r_base      <= vga_req_addr;
        r_len       <= vga_req_len;
        r_issued    <= '0;
        r_req_ready <= 1'b1;
      end else if (w_acc) begin
        r_issued <= r_issued + 1'b1;
      end
      if (r_state == ARB_IDLE && w_next == ARB_WR)
        r_starve <= '0;
      else if (w_rd_done && wr_valid && (r_starve != SW'(WR_FAIR)))
        r_starve <= r_starve + 1'b1;
      r_rvalid <= w_rdv_ok;
      if (w_rdv_ok)
        r_rdata <= m_readdata;
    end
  end
endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench: stimulus pushes expected reads/writes/data into queues, and a
// negedge monitor with a small Avalon slave model pops and compares them.
module tb_sdram_access_arbiter;
  import vga_mem_pkg::*;

  logic              clk = 1'b0, reset = 1'b1;
  logic              vga_req_valid = 0;
  logic [ADDR_W-1:0] vga_req_addr = '0;
  logic [LEN_W-1:0]  vga_req_len = '0;
  logic              vga_req_ready, vga_rvalid, wr_ready;
  logic [DATA_W-1:0] vga_rdata;
  logic              wr_valid = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write, busy;
  logic [DATA_W-1:0] m_writedata;
  logic [1:0]        m_byteenable;
  logic              m_waitrequest = 0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 0;

  always #10 clk = ~clk;

  sdram_access_arbiter dut (
    .clk(clk), .reset(reset),
    .vga_req_valid(vga_req_valid), .vga_req_addr(vga_req_addr), .vga_req_len(vga_req_len),
    .vga_req_ready(vga_req_ready), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .busy(busy)
  );

  typedef struct { int due; logic [DATA_W-1:0] d; } resp_t;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cnt = 0, rv_cnt = 0, rdy_cnt = 0, wrr_cnt = 0;
  int stall_at = -1, stall_len = 0, stall_cnt = 0, acc_limit = 1 << 30;
  bit rdv_hold = 0;
  logic [ADDR_W-1:0] hold_exp = '0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] exp_wa[$];
  logic [DATA_W-1:0] exp_wd[$];
  resp_t             resp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave memory contents: each word holds a scrambled copy of its address.
  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Avalon slave model + monitor
  initial begin
    bit stalled;
    forever begin
      @(negedge clk);
      if (!rdv_hold && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata      = resp_q[0].d;
        void'(resp_q.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = 16'hDEAD;
      end
      stalled = m_read && (acc_cnt == stall_at) && (stall_cnt < stall_len);
      m_waitrequest = m_read && ((acc_cnt >= acc_limit) || stalled);
      if (stalled) stall_cnt++;
      #1;
      if (stalled) begin
        chk("wait_hold_read", m_read, 1);
        chk("wait_hold_addr", m_address, hold_exp);
      end
      if (m_read && !m_waitrequest) begin
        if (exp_addr.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", m_address, exp_addr.pop_front());
        chk("rd_byteenable", m_byteenable, 2'b11);
        resp_q.push_back('{due: cyc + 2, d: mem_f(m_address)});
        acc_cnt++;
      end
      if (m_write && !m_waitrequest) begin
        chk("wr_ready_on_accept", wr_ready, 1);
        if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", m_address, exp_wa.pop_front());
          chk("wr_data", m_writedata, exp_wd.pop_front());
        end
      end
      if (wr_ready) wrr_cnt++;
      if (vga_req_ready) rdy_cnt++;
      if (vga_rvalid) begin
        rv_cnt++;
        if (exp_data.size() == 0) chk("rvalid_unexpected", 1, 0);
        else chk("rdata", vga_rdata, exp_data.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {m_read, m_write, wr_ready, vga_req_ready, vga_rvalid, busy}, 0);
    chk({tag, "_addr"}, m_address, 0);
    chk({tag, "_be_wdata"}, {m_byteenable, m_writedata}, 0);
    chk({tag, "_rdata"}, vga_rdata, 0);
  endtask

  task automatic vga_burst(input logic [ADDR_W-1:0] a, input int len, input int n_acc,
                           input bit push_data);
    int r0, t;
    for (int i = 0; i < n_acc; i++) begin
      exp_addr.push_back(a + ADDR_W'(i));
      if (push_data) exp_data.push_back(mem_f(a + ADDR_W'(i)));
    end
    r0 = rdy_cnt;
    @(posedge clk); #1;
    vga_req_valid = 1'b1;
    vga_req_addr  = a;
    vga_req_len   = LEN_W'(len);
    t = 0;
    while (rdy_cnt == r0 && t < 50) begin tick(); t++; end
    chk("req_ready_pulse", rdy_cnt - r0, 1);
    @(posedge clk); #1;
    vga_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    tick();
    while (busy && t < 300) begin tick(); t++; end
    chk({tag, "_busy_low"}, busy, 0);
    tick();
    chk({tag, "_queues_empty"}, exp_addr.size() + exp_data.size() + exp_wa.size(), 0);
  endtask

  initial begin
    int base, rv0, r0, w0, t;
    #5;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: plain burst
    base = acc_cnt; rv0 = rv_cnt;
    vga_burst(25'h100, 4, 4, 1);
    wait_idle("t1");
    chk("t1_accepts", acc_cnt - base, 4);
    chk("t1_rvalids", rv_cnt - rv0, 4);

    // 2: waitrequest held 3 clk on the second read
    base = acc_cnt; stall_at = base + 1; stall_len = 3; stall_cnt = 0; hold_exp = 25'h101;
    vga_burst(25'h100, 4, 4, 1);
    wait_idle("t2");
    chk("t2_accepts", acc_cnt - base, 4);
    chk("t2_stall_cycles", stall_cnt, 3);
    stall_at = -1;

    // 3: write forced after WR_FAIR bursts with VGA requesting continuously
    r0 = rdy_cnt; w0 = wrr_cnt; base = acc_cnt;
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 2; i++) begin
        exp_addr.push_back(25'h500 + ADDR_W'(i));
        exp_data.push_back(mem_f(25'h500 + ADDR_W'(i)));
      end
    exp_wa.push_back(25'h2000); exp_wd.push_back(16'hBEEF);
    @(posedge clk); #1;
    vga_req_valid = 1'b1; vga_req_addr = 25'h500; vga_req_len = LEN_W'(2);
    wr_valid = 1'b1; wr_addr = 25'h2000; wr_data = 16'hBEEF;
    t = 0;
    while (wrr_cnt == w0 && t < 400) begin tick(); t++; end
    chk("t3_bursts_before_write", rdy_cnt - r0, 4);
    @(posedge clk); #1 wr_valid = 1'b0;
    t = 0;
    while (rdy_cnt - r0 < 5 && t < 100) begin tick(); t++; end
    @(posedge clk); #1 vga_req_valid = 1'b0;
    wait_idle("t3");
    chk("t3_wr_ready_pulses", wrr_cnt - w0, 1);
    chk("t3_total_reads", acc_cnt - base, 10);

    // 4: outstanding-read limit
    rdv_hold = 1; base = acc_cnt; rv0 = rv_cnt;
    vga_burst(25'h400, 16, 16, 1);
    repeat (20) tick();
    chk("t4_accepts_at_limit", acc_cnt - base, 8);
    chk("t4_m_read_low", m_read, 0);
    rdv_hold = 0;
    wait_idle("t4");
    chk("t4_accepts", acc_cnt - base, 16);
    chk("t4_rvalids", rv_cnt - rv0, 16);

    // 5: address wrap, then zero-length burst
    vga_burst(25'h1FFFFFE, 4, 4, 1);
    wait_idle("t5w");
    base = acc_cnt; r0 = rdy_cnt;
    vga_burst(25'h7, 0, 0, 1);
    wait_idle("t5z");
    chk("t5_len0_accepts", acc_cnt - base, 0);
    chk("t5_len0_ready", rdy_cnt - r0, 1);

    // 6: reset with 3 reads outstanding; their late data must be dropped
    rdv_hold = 1; base = acc_cnt; acc_limit = base + 3;
    vga_burst(25'h300, 4, 3, 0);
    t = 0;
    while (acc_cnt - base < 3 && t < 50) begin tick(); t++; end
    tick();
    chk("t6_accepts_before_reset", acc_cnt - base, 3);
    chk("t6_busy_pending", busy, 1);
    @(posedge clk); #3 reset = 1'b1;
    #1 check_zero("t6_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    acc_limit = 1 << 30; rdv_hold = 0; rv0 = rv_cnt;
    repeat (10) tick();
    chk("t6_stale_rvalid", rv_cnt - rv0, 0);
    chk("t6_stale_drained", resp_q.size(), 0);
    chk("t6_busy_after", busy, 0);
    base = acc_cnt; rv0 = rv_cnt;
    vga_burst(25'h310, 2, 2, 1);
    wait_idle("t6n");
    chk("t6_next_accepts", acc_cnt - base, 2);
    chk("t6_next_rvalids", rv_cnt - rv0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
